// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the 4-requester round-robin arbiter.
// rr_pick is the reference pick used to cross-check the rr_pick4 network.
package rr_arb_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Walk from the lowest-priority offset down so the offset nearest ptr wins.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                      input logic [IDX_W-1:0] ptr);
        pick_t            p;
        logic [IDX_W-1:0] k;
        p = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            k = ptr + IDX_W'(i);
            if (req[k]) begin
                p.found = 1'b1;
                p.idx   = k;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: rotate requests by ptr, find the first
// set bit, then rotate the found position back into an absolute index.
module rr_pick4
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [2*N_REQ-1:0] doubled;
    logic [N_REQ-1:0]   rotated;
    logic [IDX_W-1:0]   pos;

    always_comb begin
        doubled = {req, req};
        rotated = doubled[ptr +: N_REQ];
        pos     = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                pos = IDX_W'(i);
            end
        end
        found = |rotated;
        idx   = pos + ptr;
    end

endmodule

// File: rtl/rr_req_arbiter4.sv
// Round-robin arbiter feeding encoder_4to2: registered one-hot grant with a
// hold timeout and a mandatory idle bubble after every release.
module rr_req_arbiter4
    import rr_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         done,
    output logic [N-1:0] grant,
    output logic         en
);

    // A zero-width counter is illegal, so keep one bit when the timeout is off.
    localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    state_t           state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic             en_q, en_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] hold_q, hold_d;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             timeout;
    logic             release_now;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        timeout     = (MAX_HOLD != 0) && (hold_q == CNT_W'(MAX_HOLD));
        release_now = done || !req[idx_q] || timeout;

        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (pick_found) begin
                    grant_d = N'(1) << pick_idx;
                    idx_d   = pick_idx;
                    hold_d  = CNT_W'(1);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (release_now) begin
                    grant_d = '0;
                    ptr_d   = idx_q + IDX_W'(1);
                    hold_d  = '0;
                    state_d = IDLE;
                end else if (hold_q != '1) begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase

        en_d = |grant_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            en_q    <= 1'b0;
            ptr_q   <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            en_q    <= en_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
        end
    end

    assign grant = grant_q;
    assign en    = en_q;

    pick_t ref_pick;
    assign ref_pick = rr_pick(req, ptr_q);

    a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
    a_en_matches: assert property (@(posedge clk) disable iff (rst) en_q == (|grant_q));
    a_no_switch: assert property (@(posedge clk) disable iff (rst)
        (grant_q != '0) |=> (grant_q == '0 || $stable(grant_q)));
    a_pick_ref: assert property (@(posedge clk) disable iff (rst)
        (pick_found == ref_pick.found) && (!pick_found || pick_idx == ref_pick.idx));

endmodule
